// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data memory responder.
//   - RV32I load/store width codes (funct3)
//   - responder FSM state type
//   - helpers for lane masks, store-data replication, address alignment,
//     funct3 legality, misalignment detection and load extension
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Stores only use B/H/W; loads may also use BU/HU.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (f3[2] && we);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == F3_H || f3 == F3_HU) && off[0]) ||
               ((f3 == F3_W) && (off != 2'b00));
    endfunction

    // Halfwords drop addr[0], words drop addr[1:0]; bytes keep both bits.
    function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return {off[1], 1'b0};
            F3_W:        return 2'b00;
            default:     return off;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return 4'b0011 << off;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data across lanes; the lane mask picks.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            F3_B:    return {4{wdata[7:0]}};
            F3_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                                input logic [1:0] off);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_BU:   return {24'h0, s[7:0]};
            F3_HU:   return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM, DEPTH x 32 bits.
//   clk    in   clock
//   we     in   4-bit byte-write enable, synchronous write
//   addr   in   word index
//   wdata  in   write data (lane-aligned)
//   rdata  out  combinational read of mem[addr]
// Contents are not reset.
module dmem_array #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the memory-stage data interface.
// Accepts one load/store at a time, performs it on a local word array and
// returns a response LATENCY cycles after acceptance.
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request channel
//   req_addr, req_we          byte address, 1 = store
//   req_funct3, req_wdata     RV32I width code, right-aligned store data
//   rsp_valid/rsp_ready       response channel
//   rsp_rdata, rsp_err        extended load data (0 for stores/errors), error flag
// Build option: DMEM_MISALIGN_CHECK_EN turns misaligned H/HU/W accesses into
// error responses; without it the low address bits are forced aligned.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is 1 only in IDLE; rsp_valid/rsp_rdata/rsp_err stay stable
// from rising until the edge where rsp_ready is 1.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_idx;
    logic [1:0]        lat_off;
    logic [2:0]        lat_f3;
    logic              lat_we;
    logic              lat_err;

    logic [ADDR_W-1:0] req_idx;
    logic [ADDR_W-1:0] mem_idx;
    logic [1:0]        req_off;
    logic              req_mis;
    logic              req_err;
    logic              accept;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              unused_addr;

    // Bits above the word index wrap.
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign req_ready = (state == ST_IDLE);
    assign req_idx   = req_addr[ADDR_W+1:2];
    assign req_off   = align_off(req_funct3, req_addr[1:0]);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign req_mis = misaligned(req_funct3, req_addr[1:0]);
`else
    assign req_mis = 1'b0;
`endif

    assign req_err   = f3_illegal(req_funct3, req_we) | req_mis;
    assign accept    = req_valid & req_ready & ~rst;
    assign mem_we    = (accept & req_we & ~req_err) ? lane_mask(req_funct3, req_off) : 4'b0000;
    assign mem_wdata = store_data(req_funct3, req_wdata);
    // The store/LATENCY==1 load uses the live request; later reads use the latch.
    assign mem_idx   = (state == ST_IDLE) ? req_idx : lat_idx;

    dmem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_idx),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            lat_idx   <= '0;
            lat_off   <= 2'b00;
            lat_f3    <= 3'b000;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_idx <= req_idx;
                        lat_off <= req_off;
                        lat_f3  <= req_funct3;
                        lat_we  <= req_we;
                        lat_err <= req_err;
                        if (LATENCY == 1) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_err;
                            rsp_rdata <= (req_err | req_we) ? 32'h0
                                       : load_extend(req_funct3, mem_rdata, req_off);
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= ST_RESP;
                        cnt       <= 4'd0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= lat_err;
                        rsp_rdata <= (lat_err | lat_we) ? 32'h0
                                   : load_extend(lat_f3, mem_rdata, lat_off);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized checks of data_mem_responder
// against a byte-addressed reference memory. Honors DMEM_MISALIGN_CHECK_EN.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] ref_mem [4096];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, 4 KB window (1024 words wrap).
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] r, output logic e);
        int n;
        int base;
        logic illegal;
        logic mis;
        logic [31:0] v;
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (f3 >= 3'd4 && we);
        mis = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis = ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'd0);
`endif
        e = illegal | mis;
        r = 32'h0;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        base = int'(addr[11:2]) * 4;
        if (n == 1) base += int'(addr[1:0]);
        else if (n == 2) base += int'(addr[1]) * 2;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
                if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
                if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
                r = v;
            end
        end
    endtask

    // One full transaction with timing, stability and handshake checks.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold,
                       output logic [31:0] got, output logic got_err);
        logic [31:0] er;
        logic ee;
        model(we, f3, addr, wdata, er, ee);
        check("req_ready_before", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            check("rsp_valid_early", {31'b0, rsp_valid}, 32'd0);
            check("req_ready_wait", {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        check("rsp_valid_on_time", {31'b0, rsp_valid}, 32'd1);
        check("rsp_rdata", rsp_rdata, er);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, ee});
        got = rsp_rdata;
        got_err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, er);
            check("hold_err", {31'b0, rsp_err}, {31'b0, ee});
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        check("req_ready_after", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] got;
        logic        gerr;
        logic [31:0] a;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Fill the test window so every later load has defined data.
        for (int i = 0; i < 64; i++) txn(1'b1, 3'd2, 32'(i * 4), $urandom, 0, got, gerr);

        // Store then load word
        txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, got, gerr);
        txn(1'b0, 3'd2, 32'h10, 32'h0, 0, got, gerr);
        check("lw_10", got, 32'hDEADBEEF);
        check("lw_10_err", {31'b0, gerr}, 32'd0);

        // Byte lanes and extension
        txn(1'b1, 3'd2, 32'h20, 32'h11223344, 0, got, gerr);
        txn(1'b1, 3'd0, 32'h21, 32'h000000F0, 0, got, gerr);
        txn(1'b0, 3'd0, 32'h21, 32'h0, 0, got, gerr);
        check("lb_21", got, 32'hFFFFFFF0);
        txn(1'b0, 3'd4, 32'h21, 32'h0, 0, got, gerr);
        check("lbu_21", got, 32'h000000F0);
        txn(1'b0, 3'd2, 32'h20, 32'h0, 0, got, gerr);
        check("lw_20", got, 32'h1122F044);

        // Backpressure
        txn(1'b0, 3'd2, 32'h10, 32'h0, 5, got, gerr);
        check("bp_lw_10", got, 32'hDEADBEEF);

        // Misaligned halfword
        txn(1'b1, 3'd2, 32'h30, 32'h8765ABCD, 0, got, gerr);
        txn(1'b0, 3'd1, 32'h31, 32'h0, 0, got, gerr);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("lh_31_mis", got, 32'h0);
        check("lh_31_err", {31'b0, gerr}, 32'd1);
`else
        check("lh_31_aligned", got, 32'hFFFFABCD);
        check("lh_31_noerr", {31'b0, gerr}, 32'd0);
`endif
        txn(1'b0, 3'd2, 32'h30, 32'h0, 0, got, gerr);
        check("lw_30", got, 32'h8765ABCD);

        // Illegal funct3 store
        txn(1'b1, 3'd2, 32'h40, 32'h0BADF00D, 0, got, gerr);
        txn(1'b1, 3'd3, 32'h40, 32'hFFFFFFFF, 0, got, gerr);
        check("ill_store_err", {31'b0, gerr}, 32'd1);
        check("ill_store_rdata", got, 32'h0);
        txn(1'b0, 3'd2, 32'h40, 32'h0, 0, got, gerr);
        check("lw_40_kept", got, 32'h0BADF00D);

        // Reset mid-WAIT: response is discarded
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("midrst_valid_later", {31'b0, rsp_valid}, 32'd0);

        // Address wrap
        txn(1'b1, 3'd2, 32'h1000, 32'hCAFEF00D, 0, got, gerr);
        txn(1'b0, 3'd2, 32'h0, 32'h0, 0, got, gerr);
        check("wrap_lw_0", got, 32'hCAFEF00D);

        // Randomized mix, including illegal codes and high address bits
        for (int t = 0; t < 300; t++) begin
            a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                $urandom_range(0, 2), got, gerr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
